// File: rtl/riscv_instr_aligner.sv
// Instruction aligner: rebuilds compressed and misaligned RISC-V instructions
// from word-aligned fetch words, using one half-word residue register.
module riscv_instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_addr_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_is_compressed_o,
    output logic        align_err_o
);

    typedef enum logic [1:0] {
        ST_ALIGNED    = 2'b00,
        ST_MISALIGNED = 2'b01,
        ST_BRANCH_MIS = 2'b10
    } state_t;

    state_t      state_r, state_n_s;
    logic [31:0] pc_r, pc_n_s;
    logic [15:0] residue_r, residue_n_s;
    logic        align_err_r;

    logic        instr_valid_s;
    logic        fetch_ready_s;
    logic        instr_c_s;
    logic        hs_s;
    logic        err_set_s;
    logic [31:0] instr_s;
    logic [31:0] exp_addr_s;

    // Any half-word whose two low bits are not 2'b11 is a 16-bit instruction.
    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

    // Next-state, datapath and handshake decode; a redirect overrides everything.
    always_comb begin
        state_n_s     = state_r;
        pc_n_s        = pc_r;
        residue_n_s   = residue_r;
        instr_valid_s = 1'b0;
        fetch_ready_s = 1'b0;
        instr_c_s     = 1'b0;
        instr_s       = 32'h0000_0000;
        hs_s          = 1'b0;
        exp_addr_s    = {pc_r[31:2], 2'b00};

        if (branch_i) begin
            pc_n_s      = branch_addr_i;
            residue_n_s = 16'h0000;
            state_n_s   = branch_addr_i[1] ? ST_BRANCH_MIS : ST_ALIGNED;
        end else begin
            case (state_r)
                ST_ALIGNED: begin
                    instr_valid_s = fetch_valid_i;
                    instr_c_s     = is_compressed(fetch_rdata_i[15:0]);
                    instr_s       = instr_c_s ? {16'h0000, fetch_rdata_i[15:0]} : fetch_rdata_i;
                    hs_s          = instr_valid_s & instr_ready_i;
                    fetch_ready_s = hs_s;
                    if (hs_s && instr_c_s) begin
                        residue_n_s = fetch_rdata_i[31:16];
                        pc_n_s      = pc_r + 32'd2;
                        state_n_s   = ST_MISALIGNED;
                    end else if (hs_s) begin
                        pc_n_s = pc_r + 32'd4;
                    end else begin
                        pc_n_s = pc_r;
                    end
                end
                ST_MISALIGNED: begin
                    if (is_compressed(residue_r)) begin
                        // Residue is a whole instruction: issue it without touching the fetch word.
                        instr_valid_s = 1'b1;
                        instr_c_s     = 1'b1;
                        instr_s       = {16'h0000, residue_r};
                        hs_s          = instr_ready_i;
                        if (hs_s) begin
                            pc_n_s    = pc_r + 32'd2;
                            state_n_s = ST_ALIGNED;
                        end else begin
                            pc_n_s = pc_r;
                        end
                    end else begin
                        instr_valid_s = fetch_valid_i;
                        instr_s       = {fetch_rdata_i[15:0], residue_r};
                        hs_s          = instr_valid_s & instr_ready_i;
                        fetch_ready_s = hs_s;
                        exp_addr_s    = {pc_r[31:2] + 30'd1, 2'b00};
                        if (hs_s) begin
                            residue_n_s = fetch_rdata_i[31:16];
                            pc_n_s      = pc_r + 32'd4;
                        end else begin
                            residue_n_s = residue_r;
                        end
                    end
                end
                ST_BRANCH_MIS: begin
                    fetch_ready_s = fetch_valid_i;
                    if (fetch_valid_i) begin
                        residue_n_s = fetch_rdata_i[31:16];
                        state_n_s   = ST_MISALIGNED;
                    end else begin
                        residue_n_s = residue_r;
                    end
                end
                default: begin
                    state_n_s = ST_ALIGNED;
                end
            endcase
        end

        err_set_s = fetch_ready_s & (fetch_addr_i != exp_addr_s);
    end

    // State, PC, residue and sticky alignment error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ALIGNED;
            pc_r        <= BOOT_ADDR;
            residue_r   <= 16'h0000;
            align_err_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            pc_r        <= pc_n_s;
            residue_r   <= residue_n_s;
            align_err_r <= align_err_r | err_set_s;
        end
    end

    assign fetch_ready_o         = fetch_ready_s;
    assign instr_valid_o         = instr_valid_s;
    assign instr_o               = instr_s;
    assign instr_addr_o          = pc_r;
    assign instr_is_compressed_o = instr_c_s & instr_valid_s;
    assign align_err_o           = align_err_r;

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Directed bench for riscv_instr_aligner: a half-word stream model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_riscv_instr_aligner;

    localparam logic [31:0] BOOT = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_addr_i = 32'h0;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_is_compressed_o;
    logic        align_err_o;

    int n_vec = 0;
    int n_err = 0;

    riscv_instr_aligner #(.BOOT_ADDR(BOOT)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_ready_o         (fetch_ready_o),
        .fetch_addr_i          (fetch_addr_i),
        .fetch_rdata_i         (fetch_rdata_i),
        .branch_i              (branch_i),
        .branch_addr_i         (branch_addr_i),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_o               (instr_o),
        .instr_addr_o          (instr_addr_o),
        .instr_is_compressed_o (instr_is_compressed_o),
        .align_err_o           (align_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the program is a stream of half-words starting at pc_m; hq holds
    // half-words already fetched but not yet issued.
    logic [15:0] hq[$];
    logic [15:0] v[$];
    logic [31:0] pc_m = BOOT;
    logic        discard_m = 1'b0;
    logic        err_m = 1'b0;

    always @(negedge clk) begin
        logic        exp_v, exp_r, exp_c, uses;
        logic [31:0] exp_i, exp_addr;
        int          need;
        if (!rst_n) begin
            pc_m = BOOT; hq.delete(); discard_m = 1'b0; err_m = 1'b0;
            chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
            chk("rst_ready", {31'h0, fetch_ready_o}, 32'h0);
            chk("rst_err",   {31'h0, align_err_o},   32'h0);
        end else begin
            exp_v = 1'b0; exp_r = 1'b0; exp_c = 1'b0; uses = 1'b0;
            exp_i = 32'h0; need = 0;
            if (branch_i) begin
                exp_r = 1'b0;
            end else if (discard_m) begin
                exp_r = fetch_valid_i;
            end else begin
                v = hq;
                if (fetch_valid_i) begin
                    v.push_back(fetch_rdata_i[15:0]);
                    v.push_back(fetch_rdata_i[31:16]);
                end
                if (v.size() > 0 && v[0][1:0] != 2'b11) begin
                    exp_v = 1'b1; exp_c = 1'b1; need = 1; exp_i = {16'h0, v[0]};
                end else if (v.size() > 1) begin
                    exp_v = 1'b1; need = 2; exp_i = {v[1], v[0]};
                end
                uses  = hq.size() < need;
                exp_r = exp_v & instr_ready_i & uses;
            end
            chk("m_valid", {31'h0, instr_valid_o}, {31'h0, exp_v});
            chk("m_ready", {31'h0, fetch_ready_o}, {31'h0, exp_r});
            chk("m_err",   {31'h0, align_err_o},   {31'h0, err_m});
            if (exp_v) begin
                chk("m_instr", instr_o, exp_i);
                chk("m_addr",  instr_addr_o, pc_m);
                chk("m_comp",  {31'h0, instr_is_compressed_o}, {31'h0, exp_c});
            end
            exp_addr = discard_m ? {pc_m[31:2], 2'b00}
                                 : ((pc_m + 32'(2 * hq.size())) & ~32'd3);
            if (exp_r && fetch_addr_i != exp_addr) err_m = 1'b1;
            if (branch_i) begin
                pc_m = branch_addr_i; hq.delete(); discard_m = branch_addr_i[1];
            end else if (discard_m) begin
                if (fetch_valid_i) begin
                    hq.push_back(fetch_rdata_i[31:16]);
                    discard_m = 1'b0;
                end
            end else if (exp_v && instr_ready_i) begin
                if (uses) begin
                    hq.push_back(fetch_rdata_i[15:0]);
                    hq.push_back(fetch_rdata_i[31:16]);
                end
                for (int k = 0; k < need; k++) void'(hq.pop_front());
                pc_m = pc_m + 32'(2 * need);
            end
        end
    end

    task automatic cyc(input logic fv, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic br, input logic [31:0] ba);
        @(posedge clk); #1;
        fetch_valid_i = fv; fetch_addr_i = a; fetch_rdata_i = d;
        instr_ready_i = rdy; branch_i = br; branch_addr_i = ba;
        #2;
    endtask

    task automatic lit(input string n, input logic [31:0] i, input logic [31:0] a,
                       input logic c, input logic r);
        chk({n, "_valid"}, {31'h0, instr_valid_o}, 32'h1);
        chk({n, "_instr"}, instr_o, i);
        chk({n, "_addr"},  instr_addr_o, a);
        chk({n, "_comp"},  {31'h0, instr_is_compressed_o}, {31'h0, c});
        chk({n, "_ready"}, {31'h0, fetch_ready_o}, {31'h0, r});
    endtask

    initial begin
        repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("idle_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("idle_ready", {31'h0, fetch_ready_o}, 32'h0);
        // Two aligned 32-bit instructions from boot
        cyc(1'b1, 32'h80, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        lit("a0", 32'h0000_0013, 32'h80, 1'b0, 1'b1);
        cyc(1'b1, 32'h84, 32'h0010_0093, 1'b1, 1'b0, 32'h0);
        lit("a1", 32'h0010_0093, 32'h84, 1'b0, 1'b1);
        // Two compressed in one word
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("br_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("br_ready", {31'h0, fetch_ready_o}, 32'h0);
        cyc(1'b1, 32'h0, 32'h4501_4505, 1'b1, 1'b0, 32'h0);
        lit("c0", 32'h0000_4505, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        lit("c1", 32'h0000_4501, 32'h2, 1'b1, 1'b0);
        // Compressed, then a 32-bit instruction straddling two words
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        cyc(1'b1, 32'h0, 32'h0013_4505, 1'b1, 1'b0, 32'h0);
        lit("s0", 32'h0000_4505, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("s_wait_valid", {31'h0, instr_valid_o}, 32'h0);
        cyc(1'b1, 32'h4, 32'h4501_0000, 1'b1, 1'b0, 32'h0);
        lit("s1", 32'h0000_0013, 32'h2, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        lit("s2", 32'h0000_4501, 32'h6, 1'b1, 1'b0);
        // Redirect to a half-word target: one bubble, then the upper half
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h102);
        cyc(1'b1, 32'h100, 32'h0001_ABCD, 1'b1, 1'b0, 32'h0);
        chk("bm_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("bm_ready", {31'h0, fetch_ready_o}, 32'h1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        lit("bm1", 32'h0000_0001, 32'h102, 1'b1, 1'b0);
        // Stall with a misaligned 32-bit instruction pending
        cyc(1'b1, 32'h104, 32'h0013_4505, 1'b1, 1'b0, 32'h0);
        lit("st0", 32'h0000_4505, 32'h104, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h108, 32'h4501_0000, 1'b0, 1'b0, 32'h0);
            lit("stall", 32'h0000_0013, 32'h106, 1'b0, 1'b0);
        end
        cyc(1'b1, 32'h108, 32'h4501_0000, 1'b1, 1'b0, 32'h0);
        lit("st1", 32'h0000_0013, 32'h106, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        lit("st2", 32'h0000_4501, 32'h10A, 1'b1, 1'b0);
        // PC wrap: 32-bit instruction at 0xFFFF_FFFE spans into word 0
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        cyc(1'b1, 32'hFFFF_FFFC, 32'h0003_1234, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h0, 32'h0005_0000, 1'b1, 1'b0, 32'h0);
        lit("wr0", 32'h0000_0003, 32'hFFFF_FFFE, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        lit("wr1", 32'h0000_0005, 32'h2, 1'b1, 1'b0);
        // Redirect during an otherwise valid handshake
        cyc(1'b1, 32'h4, 32'h0000_0013, 1'b1, 1'b1, 32'h4);
        chk("brh_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("brh_ready", {31'h0, fetch_ready_o}, 32'h0);
        // Wrong fetch address sets the sticky error
        cyc(1'b1, 32'h8, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        chk("err_before", {31'h0, align_err_o}, 32'h0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("err_set", {31'h0, align_err_o}, 32'h1);
        repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("err_sticky", {31'h0, align_err_o}, 32'h1);
        // Asynchronous reset mid-cycle
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk("arst_err", {31'h0, align_err_o}, 32'h0);
        chk("arst_addr", instr_addr_o, BOOT);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1'b1, 32'h80, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        lit("post", 32'h0000_0013, 32'h80, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
